// File: rtl/apb3_cmd_initiator_pkg.sv
// ---------------------------------------------------------------------------
// apb3_cmd_pkg
// Shared types and constants for the APB3 command initiator:
//   - state_e    : transfer FSM states (IDLE, SETUP, ACCESS)
//   - cmd_t      : one queued command {write, addr, wdata}, 65 bits packed
//   - APB_DATA_W / APB_ADDR_W : APB bus widths
//   - rsp_data_sel : response data selection (writes and aborts return zero)
// ---------------------------------------------------------------------------
package apb3_cmd_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } cmd_t;

  // Read data is only meaningful for a read that completed on PREADY;
  // writes and timed-out transfers report zero.
  function automatic logic [APB_DATA_W-1:0] rsp_data_sel(
    input logic                  is_write,
    input logic                  aborted,
    input logic [APB_DATA_W-1:0] prdata
  );
    logic [APB_DATA_W-1:0] data;
    if (is_write || aborted) begin
      data = {APB_DATA_W{1'b0}};
    end else begin
      data = prdata;
    end
    return data;
  endfunction

endpackage

// File: rtl/apb3_cmd_initiator_if.sv
// ---------------------------------------------------------------------------
// apb3_cmd_initiator_if
// Bundles the command request side, the response side and the APB3 bus of
// the command initiator.
//   master modport : initiator view (drives cmd_ready, rsp_*, busy, APB Pxxx)
//   slave  modport : environment view (requesters and APB responder)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command request
//   rsp_valid/rsp_rdata/rsp_err                      : per-transfer response
//   busy                                             : work pending/in flight
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR : APB3 bus
// ---------------------------------------------------------------------------
interface apb3_cmd_initiator_if;
  import apb3_cmd_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [APB_ADDR_W-1:0] cmd_addr;
  logic [APB_DATA_W-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb3_cmd_initiator_fifo.sv
// ---------------------------------------------------------------------------
// apb3_cmd_fifo
// Synchronous command FIFO with a registered head output.
// Parameters: FIFO_DEPTH (power of 2, 2..16)
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_push         : write i_push_data (ignored while full)
//   i_push_data    : command to enqueue
//   i_pop          : drop the head entry (ignored while empty)
//   o_full/o_empty : occupancy flags
//   o_head         : registered copy of the oldest entry
// ---------------------------------------------------------------------------
module apb3_cmd_fifo
  import apb3_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  cmd_t i_push_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output cmd_t o_head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr_inc;
  logic [CW-1:0] r_count;
  cmd_t          r_head;
  cmd_t          w_head_next;
  logic          w_push;
  logic          w_pop;

  assign o_full       = (r_count == CNT_FULL);
  assign o_empty      = (r_count == CNT_ZERO);
  assign w_push       = i_push & ~o_full;
  assign w_pop        = i_pop & ~o_empty;
  // Depth is a power of two, so the pointer wraps naturally.
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
  assign o_head       = r_head;

  // Next head: the entry behind the popped one, or the pushed command when it
  // lands in an empty (or emptying) FIFO.
  always_comb begin
    w_head_next = r_head;
    if (w_pop) begin
      if (r_count > CNT_ONE) begin
        w_head_next = r_mem[w_rd_ptr_inc];
      end else if (w_push) begin
        w_head_next = i_push_data;
      end else begin
        w_head_next = '0;
      end
    end else if (w_push && (r_count == CNT_ZERO)) begin
      w_head_next = i_push_data;
    end else begin
      w_head_next = r_head;
    end
  end

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CNT_ZERO;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_head <= w_head_next;
    end
  end

endmodule

// File: rtl/apb3_cmd_initiator.sv
// ---------------------------------------------------------------------------
// apb3_cmd_initiator
// APB3 initiator: queued command requests become APB3 SETUP/ACCESS transfers,
// and each completed transfer yields one response pulse in command order.
// Parameters:
//   FIFO_DEPTH     : command FIFO entries (power of 2, 2..16)
//   TIMEOUT_CYCLES : ACCESS cycles with PREADY=0 before abort (timeout build)
// Configuration macro:
//   APB_TIMEOUT_EN : when defined, a stalled ACCESS phase is aborted after
//                    TIMEOUT_CYCLES wait cycles and reported with rsp_err=1.
// Ports:
//   PCLK   : clock, rising edge
//   PRESET : asynchronous active-high reset
//   bus    : apb3_cmd_initiator_if.master (command, response, APB3 bus)
// ---------------------------------------------------------------------------
module apb3_cmd_initiator
  import apb3_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  apb3_cmd_initiator_if.master        bus
);

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("apb3_cmd_initiator: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  state_e                r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [APB_ADDR_W-1:0] r_paddr;
  logic [APB_DATA_W-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [APB_DATA_W-1:0] r_rsp_rdata;

  cmd_t                  w_push_data;
  cmd_t                  w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_tmo;
  logic                  w_done;

  assign w_push_data = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  assign w_push      = bus.cmd_valid & ~w_full;
  assign w_done      = bus.PREADY | w_tmo;

  // The head is consumed when a transfer is launched, either from IDLE or
  // straight out of a completing ACCESS phase (back-to-back).
  always_comb begin
    w_pop = 1'b0;
    if ((r_state == IDLE) && !w_empty) begin
      w_pop = 1'b1;
    end else if ((r_state == ACCESS) && w_done && !w_empty) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
  end

  apb3_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (PCLK),
    .i_rst       (PRESET),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // The abort fires in the last permitted wait cycle, so ACCESS lasts exactly
  // TIMEOUT_CYCLES cycles with PREADY low.
  assign w_tmo = (r_state == ACCESS) && !bus.PREADY && (r_tmo_cnt == TMO_LAST);

  // Count ACCESS wait cycles; cleared whenever the transfer is not waiting.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tmo_cnt <= TMO_W'(0);
    end else if ((r_state == ACCESS) && !bus.PREADY && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= TMO_W'(0);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= {APB_ADDR_W{1'b0}};
      r_pwdata    <= {APB_DATA_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= {APB_DATA_W{1'b0}};
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= {APB_DATA_W{1'b0}};
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state   <= SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= w_head.write;
            r_paddr   <= w_head.addr;
            r_pwdata  <= w_head.wdata;
          end else begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_psel    <= 1'b1;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_tmo | bus.PSLVERR;
            r_rsp_rdata <= rsp_data_sel(r_pwrite, w_tmo, bus.PRDATA);
            if (!w_empty) begin
              r_state   <= SETUP;
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_pwrite  <= w_head.write;
              r_paddr   <= w_head.addr;
              r_pwdata  <= w_head.wdata;
            end else begin
              r_state   <= IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end else begin
            r_state   <= ACCESS;
            r_psel    <= 1'b1;
            r_penable <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.cmd_ready = ~w_full;
  assign bus.busy      = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_apb3_cmd_initiator.sv
// ---------------------------------------------------------------------------
// tb_apb3_cmd_initiator
// Scoreboard bench: every accepted command pushes its expected response; a
// monitor pops and compares on each rsp_valid. Scenario tasks add inline
// timing/bus checks. A behavioural APB responder returns
// PRDATA = {16'hA5A5, PADDR[15:0]} and PSLVERR for address 0x8, with
// configurable wait states or an indefinite stall.
// ---------------------------------------------------------------------------
module tb_apb3_cmd_initiator;
  import apb3_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst;

  apb3_cmd_initiator_if bus ();

  apb3_cmd_initiator #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus.master)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic cfg_stall = 1'b0;
  int   cfg_wait  = 0;

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  // Clock
  initial forever #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // APB responder; garbage PRDATA/PSLVERR while not ready
  initial begin
    int wcnt;
    wcnt = 0;
    bus.PREADY  = 1'b0;
    bus.PRDATA  = 32'h0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b0) begin
        wcnt        = cfg_wait;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'h0;
        bus.PSLVERR = 1'b0;
      end else if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
        if (cfg_stall || wcnt > 0) begin
          bus.PREADY  = 1'b0;
          bus.PRDATA  = 32'hDEAD_BEEF;
          bus.PSLVERR = 1'b1;
          if (!cfg_stall) wcnt--;
        end else begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = model_rdata(bus.PADDR);
          bus.PSLVERR = (bus.PADDR == 32'h8);
        end
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'h0;
        bus.PSLVERR = 1'b0;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h err=%b, required no response",
                   bus.rsp_rdata, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata: got %h, required %h", bus.rsp_rdata, e.rdata);
          end
          checks++;
          if (bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_err: got %b, required %b", bus.rsp_err, e.err);
          end
        end
      end
    end
  end

  // Drive one command starting at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic tmo);
    exp_t e;
    int   n;
    n             = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (bus.cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready stayed %b, required 1", bus.cmd_ready);
      bus.cmd_valid = 1'b0;
    end else begin
      e.rdata = (w || tmo) ? 32'h0 : model_rdata(a);
      e.err   = tmo || (a == 32'h8);
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b, required 0", tag, bus.busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_rsp_count: %0d responses missing, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.busy, bus.cmd_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000001",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.busy, bus.cmd_ready});
    end
    checks++;
    if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {bus.PADDR, bus.PWDATA, bus.rsp_rdata});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.PSEL, bus.busy, bus.cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL post_reset: got %b, required 001", {bus.PSEL, bus.busy, bus.cmd_ready});
    end
  endtask

  task automatic test_single_write();
    send_cmd(1'b1, 32'h4, 32'h0, 1'b0);
    // cycle N
    checks++;
    if ({bus.PSEL, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL wr_cycleN: psel,busy got %b, required 01", {bus.PSEL, bus.busy});
    end
    @(negedge clk); // N+1: SETUP
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {3'b101, 32'h4, 32'h0}) begin
      errors++;
      $display("FAIL wr_setup: got sel/en/wr=%b addr=%h wdata=%h, required 101 4 0",
               {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA);
    end
    @(negedge clk); // N+2: ACCESS
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b111, 32'h4}) begin
      errors++;
      $display("FAIL wr_access: got sel/en/wr=%b addr=%h, required 111 4",
               {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR);
    end
    @(negedge clk); // N+3: response, bus idle, address held
    checks++;
    if ({bus.rsp_valid, bus.PSEL, bus.PENABLE, bus.PADDR} !== {3'b100, 32'h4}) begin
      errors++;
      $display("FAIL wr_resp: got valid/sel/en=%b addr=%h, required 100 4",
               {bus.rsp_valid, bus.PSEL, bus.PENABLE}, bus.PADDR);
    end
    wait_idle("single_write");
  endtask

  task automatic test_read_wait();
    int  acc;
    bit  prev_acc;
    bit  seen;
    acc      = 0;
    prev_acc = 1'b0;
    seen     = 1'b0;
    cfg_wait = 2;
    send_cmd(1'b0, 32'h1, 32'h0, 1'b0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (!prev_acc || bus.rsp_rdata !== 32'hA5A5_0001) begin
          errors++;
          $display("FAIL rd_wait_resp: prev_access=%b rdata=%h, required 1 a5a50001",
                   prev_acc, bus.rsp_rdata);
        end
      end else begin
        prev_acc = (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1);
        if (prev_acc) acc++;
      end
    end
    checks++;
    if (!seen || acc != 3) begin
      errors++;
      $display("FAIL rd_wait_len: access cycles %0d seen=%b, required 3 1", acc, seen);
    end
    cfg_wait = 0;
    wait_idle("read_wait");
  endtask

  task automatic test_back_to_back();
    int nresp;
    int gaps;
    nresp     = 0;
    gaps      = 0;
    cfg_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_cmd(1'(i % 2), 32'h100 + 32'(i * 4), 32'h1000 + 32'(i), 1'b0);
    end
    checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_full: cmd_ready,busy got %b, required 01", {bus.cmd_ready, bus.busy});
    end
    cfg_stall = 1'b0;
    for (int i = 0; i < 100 && nresp < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) nresp++;
      if (nresp < 5 && bus.PSEL !== 1'b1) gaps++;
    end
    checks++;
    if (nresp != 5 || gaps != 0) begin
      errors++;
      $display("FAIL b2b_stream: responses %0d gaps %0d, required 5 0", nresp, gaps);
    end
    wait_idle("back_to_back");
  endtask

  task automatic test_slverr();
    send_cmd(1'b1, 32'h8, 32'hCAFE_0008, 1'b0);
    send_cmd(1'b0, 32'h10, 32'h0, 1'b0);
    wait_idle("slverr");
  endtask

  task automatic test_reset_mid();
    int n;
    n         = 0;
    cfg_stall = 1'b1;
    send_cmd(1'b0, 32'h20, 32'h0, 1'b0);
    send_cmd(1'b1, 32'h24, 32'h5, 1'b0);
    send_cmd(1'b1, 32'h28, 32'h6, 1'b0);
    for (int i = 0; i < 10 && !(bus.PSEL === 1'b1 && bus.PENABLE === 1'b1); i++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready, bus.rsp_valid} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_mid: sel/en/busy/ready/valid got %b, required 00010",
               {bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready, bus.rsp_valid});
    end
    exp_q.delete();
    @(negedge clk);
    rst       = 1'b0;
    cfg_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 || bus.PSEL === 1'b1) n++;
    end
    checks++;
    if (n != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: activity cycles %0d busy=%b, required 0 0", n, bus.busy);
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    bit seen;
    acc       = 0;
    seen      = 1'b0;
    cfg_stall = 1'b1;
    send_cmd(1'b0, 32'h30, 32'h0, 1'b1);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if ({bus.rsp_err, bus.rsp_rdata, bus.PSEL} !== {1'b1, 32'h0, 1'b0}) begin
          errors++;
          $display("FAIL tmo_resp: err=%b rdata=%h psel=%b, required 1 0 0",
                   bus.rsp_err, bus.rsp_rdata, bus.PSEL);
        end
      end else if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
        acc++;
      end
    end
    checks++;
    if (!seen || acc != 8) begin
      errors++;
      $display("FAIL tmo_len: access cycles %0d seen=%b, required 8 1", acc, seen);
    end
    cfg_stall = 1'b0;
    wait_idle("timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
